// File: rtl/saph_pkg.sv
// Shared SAPH types: binary32 float layout, canonical special values, FSM state codes.
// Pure declarations, no timing or flow control.
package saph_pkg;

    typedef logic [31:0] float_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float_fields_t;

    localparam float_t FLOAT_QNAN = 32'h7FC0_0000;
    localparam float_t FLOAT_PINF = 32'h7F80_0000;
    localparam float_t FLOAT_NINF = 32'hFF80_0000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ALIGN = 3'd1;
    localparam state_t ST_ADD   = 3'd2;
    localparam state_t ST_NORM  = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/saph_fpu_add_responder_if.sv
// Per-port FPU add request/response bundle; master = initiators, slave = shared adder.
// Valid/ready on both directions; requests must hold stable until accepted.
interface saph_fpu_add_responder_if #(
    parameter int PORTS = 2
);
    import saph_pkg::*;

    logic   [PORTS-1:0] req_valid;
    logic   [PORTS-1:0] req_ready;
    float_t [PORTS-1:0] req_a;
    float_t [PORTS-1:0] req_b;
    logic   [PORTS-1:0] req_sub;
    logic   [PORTS-1:0] resp_valid;
    logic   [PORTS-1:0] resp_ready;
    float_t [PORTS-1:0] resp_data;

    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/saph_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or above ptr, wrapping; one-hot grant.
// Purely combinational, no state; caller owns the pointer.
module saph_rr_arbiter #(
    parameter int PORTS = 2,
    parameter int PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PORTS-1:0] gnt
);

    logic [PORTS-1:0] mask;
    logic [PORTS-1:0] hi;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PORTS; i++) begin
            mask[i] = (PW'(i) >= ptr);
        end
    end

    // Isolate lowest set bit; fall back to the full vector when nothing sits at/above ptr.
    assign hi  = req & mask;
    assign gnt = (|hi) ? (hi & (~hi + PORTS'(1))) : (req & (~req + PORTS'(1)));

endmodule

// File: rtl/saph_fpu_add_responder.sv
// Shared binary32 add/sub unit serving PORTS initiators round-robin, one op at a time.
// Accept at T gives resp_valid at T+4; result held until resp_ready, no accepts outside IDLE.
module saph_fpu_add_responder
    import saph_pkg::*;
#(
    parameter int PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    saph_fpu_add_responder_if.slave  bus
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   gnt_idx;
    logic [PORTS-1:0] gnt;

    float_t          op_a, op_b;
    logic            op_sub;

    float_fields_t   fa, fb;
    logic            sb_eff, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
    logic            sign_big, sign_small, spec_vld;
    logic [7:0]      exp_big, exp_small, exp_diff;
    logic [26:0]     ma, mb, mant_big, mant_raw_small, mant_small;
    float_t          spec_val;

    logic            sign_l_q, sign_s_q, spec_vld_q;
    logic [7:0]      exp_q;
    logic [26:0]     mant_l_q, mant_s_q;
    float_t          spec_val_q;
    logic [27:0]     sum_q;
    float_t          res_q;

    logic [4:0]      lzc;
    logic            lz_found;
    logic [26:0]     norm_sh;
    logic [9:0]      exp_n;
    logic [22:0]     frac_n;
    float_t          norm_res;

    saph_rr_arbiter #(.PORTS(PORTS), .PW(PW)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    always_comb begin
        bus.req_ready  = (state == ST_IDLE && rst_n) ? gnt : '0;
        bus.resp_valid = '0;
        bus.resp_data  = '0;
        if (state == ST_RESP) begin
            bus.resp_valid[winner] = 1'b1;
            bus.resp_data[winner]  = res_q;
        end
    end

    // Unpack, order by magnitude and align; denormals are treated as zero throughout.
    always_comb begin
        fa        = float_fields_t'(op_a);
        fb        = float_fields_t'(op_b);
        sb_eff    = fb.sign ^ op_sub;
        a_zero    = (fa.exp == 8'd0);
        b_zero    = (fb.exp == 8'd0);
        a_nan     = (fa.exp == 8'hFF) && (fa.frac != 23'd0);
        b_nan     = (fb.exp == 8'hFF) && (fb.frac != 23'd0);
        a_inf     = (fa.exp == 8'hFF) && (fa.frac == 23'd0);
        b_inf     = (fb.exp == 8'hFF) && (fb.frac == 23'd0);
        ma        = a_zero ? 27'd0 : {1'b1, fa.frac, 3'b000};
        mb        = b_zero ? 27'd0 : {1'b1, fb.frac, 3'b000};
        a_big     = {fa.exp, (a_zero ? 23'd0 : fa.frac)} >= {fb.exp, (b_zero ? 23'd0 : fb.frac)};
        sign_big       = a_big ? fa.sign : sb_eff;
        sign_small     = a_big ? sb_eff  : fa.sign;
        exp_big        = a_big ? fa.exp  : fb.exp;
        exp_small      = a_big ? fb.exp  : fa.exp;
        mant_big       = a_big ? ma : mb;
        mant_raw_small = a_big ? mb : ma;
        exp_diff       = exp_big - exp_small;
        mant_small     = (exp_diff >= 8'd27) ? 27'd0 : (mant_raw_small >> exp_diff);

        spec_vld = 1'b1;
        spec_val = FLOAT_QNAN;
        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != sb_eff))) begin
            spec_val = FLOAT_QNAN;
        end else if (a_inf) begin
            spec_val = fa.sign ? FLOAT_NINF : FLOAT_PINF;
        end else if (b_inf) begin
            spec_val = sb_eff ? FLOAT_NINF : FLOAT_PINF;
        end else begin
            spec_vld = 1'b0;
        end
    end

    always_comb begin
        lzc      = 5'd0;
        lz_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum_q[i]) lz_found = 1'b1;
                else          lzc      = lzc + 5'd1;
            end
        end
        norm_sh = sum_q[26:0] << lzc;
        if (sum_q[27]) begin
            exp_n  = {2'b00, exp_q} + 10'd1;
            frac_n = sum_q[26:4];
        end else begin
            exp_n  = {2'b00, exp_q} - {5'd0, lzc};
            frac_n = 23'(norm_sh >> 3);
        end

        // Exact cancellation is +0; only two same-signed negative zeros keep -0.
        if (spec_vld_q)                          norm_res = spec_val_q;
        else if (sum_q == 28'd0)                 norm_res = {sign_l_q & sign_s_q, 31'd0};
        else if (exp_n[9] || exp_n == 10'd0)     norm_res = {sign_l_q, 31'd0};
        else if (exp_n >= 10'd255)               norm_res = {sign_l_q, 8'hFF, 23'd0};
        else                                     norm_res = {sign_l_q, exp_n[7:0], frac_n};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            winner     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            sign_l_q   <= 1'b0;
            sign_s_q   <= 1'b0;
            exp_q      <= '0;
            mant_l_q   <= '0;
            mant_s_q   <= '0;
            spec_vld_q <= 1'b0;
            spec_val_q <= '0;
            sum_q      <= '0;
            res_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.req_ready) begin
                        op_a   <= bus.req_a[gnt_idx];
                        op_b   <= bus.req_b[gnt_idx];
                        op_sub <= bus.req_sub[gnt_idx];
                        winner <= gnt_idx;
                        ptr    <= (gnt_idx == PW'(PORTS - 1)) ? '0 : gnt_idx + PW'(1);
                        state  <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    sign_l_q   <= sign_big;
                    sign_s_q   <= sign_small;
                    exp_q      <= exp_big;
                    mant_l_q   <= mant_big;
                    mant_s_q   <= mant_small;
                    spec_vld_q <= spec_vld;
                    spec_val_q <= spec_val;
                    state      <= ST_ADD;
                end
                ST_ADD: begin
                    sum_q <= (sign_l_q == sign_s_q) ? ({1'b0, mant_l_q} + {1'b0, mant_s_q})
                                                    : ({1'b0, mant_l_q} - {1'b0, mant_s_q});
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    res_q <= norm_res;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready[winner]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
